// File: rtl/half_adder_pkg.sv
// Shared types and the single-lane half-adder equation used by the adder slice.
package half_adder_pkg;

   localparam int HA_DEFAULT_WIDTH = 1;

   typedef struct packed {
      logic carry;
      logic sum;
   } ha_res_t;

   function automatic ha_res_t ha_eval(input logic a, input logic b);
      ha_res_t r;
      r.sum   = a ^ b;
      r.carry = a & b;
      return r;
   endfunction

endpackage

// File: rtl/half_adder_ha_bit.sv
// One-bit combinational half adder; lanes are fully independent of each other.
module ha_bit
   import half_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   ha_res_t res;

   assign res   = ha_eval(a, b);
   assign sum   = res.sum;
   assign carry = res.carry;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with an optional one-cycle registered copy.
module half_adder
   import half_adder_pkg::*;
#(
   parameter int WIDTH  = HA_DEFAULT_WIDTH,
   parameter bit REG_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] ip1,
   input  logic [WIDTH-1:0] ip2,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   output logic [WIDTH-1:0] sum_q,
   output logic [WIDTH-1:0] carry_q,
   output logic             out_valid
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      ha_bit u_ha_bit (
         .a     (ip1[i]),
         .b     (ip2[i]),
         .sum   (sum[i]),
         .carry (carry[i])
      );
   end

   if (REG_EN) begin : g_reg
      logic [WIDTH-1:0] sum_d;
      logic [WIDTH-1:0] carry_d;
      logic             out_valid_d;
      logic             out_valid_q;

      // Result registers only load on accepted inputs; otherwise they hold.
      always_comb begin
         sum_d       = sum_q;
         carry_d     = carry_q;
         out_valid_d = in_valid;
         if (in_valid) begin
            sum_d   = sum;
            carry_d = carry;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sum_q       <= '0;
            carry_q     <= '0;
            out_valid_q <= 1'b0;
         end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
         end
      end

      assign out_valid = out_valid_q;
   end else begin : g_noreg
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst, in_valid};
      assign sum_q      = '0;
      assign carry_q    = '0;
      assign out_valid  = 1'b0;
   end

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: arithmetic reference model plus literal spot checks.
module tb_half_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       v4 = 1'b0;
   logic [1:0] a0 = '0, b0 = '0;
   logic       v0 = 1'b0;

   logic       s1, c1, sq1, cq1, ov1;
   logic [3:0] s4, c4, sq4, cq4;
   logic       ov4;
   logic [1:0] s0, c0, sq0, cq0;
   logic       ov0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   half_adder #(.WIDTH(1), .REG_EN(1'b1)) dut1 (
      .clk(clk), .rst(rst), .ip1(a1), .ip2(b1), .in_valid(v1),
      .sum(s1), .carry(c1), .sum_q(sq1), .carry_q(cq1), .out_valid(ov1));

   half_adder #(.WIDTH(4), .REG_EN(1'b1)) dut4 (
      .clk(clk), .rst(rst), .ip1(a4), .ip2(b4), .in_valid(v4),
      .sum(s4), .carry(c4), .sum_q(sq4), .carry_q(cq4), .out_valid(ov4));

   half_adder #(.WIDTH(2), .REG_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .ip1(a0), .ip2(b0), .in_valid(v0),
      .sum(s0), .carry(c0), .sum_q(sq0), .carry_q(cq0), .out_valid(ov0));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: each lane adds two bits as integers; low bit is sum, high bit is carry.
   function automatic int lane_add(input logic a, input logic b);
      return int'(a) + int'(b);
   endfunction

   logic       m1_sq = 0, m1_cq = 0, m1_ov = 0;
   logic [3:0] m4_sq = '0, m4_cq = '0;
   logic       m4_ov = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m1_sq = 0; m1_cq = 0; m1_ov = 0;
         m4_sq = '0; m4_cq = '0; m4_ov = 0;
      end else begin
         m1_ov = v1;
         if (v1) begin
            m1_sq = lane_add(a1, b1) % 2 == 1;
            m1_cq = lane_add(a1, b1) / 2 == 1;
         end
         m4_ov = v4;
         if (v4)
            for (int i = 0; i < 4; i++) begin
               m4_sq[i] = lane_add(a4[i], b4[i]) % 2 == 1;
               m4_cq[i] = lane_add(a4[i], b4[i]) / 2 == 1;
            end
      end
   end

   // Per-cycle comparison of every DUT against the model, mid-cycle.
   always @(negedge clk) begin
      chk("w1_sum",   32'(s1), 32'(lane_add(a1, b1) % 2));
      chk("w1_carry", 32'(c1), 32'(lane_add(a1, b1) / 2));
      chk("w1_sum_q", 32'(sq1), 32'(m1_sq));
      chk("w1_carry_q", 32'(cq1), 32'(m1_cq));
      chk("w1_out_valid", 32'(ov1), 32'(m1_ov));
      for (int i = 0; i < 4; i++)
         if (!$isunknown({a4[i], b4[i]})) begin
            chk("w4_sum_lane",   32'(s4[i]), 32'(lane_add(a4[i], b4[i]) % 2));
            chk("w4_carry_lane", 32'(c4[i]), 32'(lane_add(a4[i], b4[i]) / 2));
         end
      chk("w4_sum_q", 32'(sq4), 32'(m4_sq));
      chk("w4_carry_q", 32'(cq4), 32'(m4_cq));
      chk("w4_out_valid", 32'(ov4), 32'(m4_ov));
      chk("noreg_sum_q", 32'(sq0), 32'd0);
      chk("noreg_carry_q", 32'(cq0), 32'd0);
      chk("noreg_out_valid", 32'(ov0), 32'd0);
      chk("noreg_sum", 32'(s0), 32'(a0 ^ b0));
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   logic [1:0] vec [4];

   initial begin
      vec[0] = 2'b00; vec[1] = 2'b01; vec[2] = 2'b10; vec[3] = 2'b11;
      step(); step();
      chk("reset_sum_q",     32'(sq1), 32'd0);
      chk("reset_carry_q",   32'(cq1), 32'd0);
      chk("reset_out_valid", 32'(ov1), 32'd0);
      rst = 1'b0;

      // Combinational truth table, 20 ns apart.
      for (int i = 0; i < 4; i++) begin
         {a1, b1} = vec[i];
         a0 = {vec[i][1], vec[i][0]}; b0 = {vec[i][0], vec[i][1]};
         #1;
         chk("tt_sum",   32'(s1), (i == 1 || i == 2) ? 32'd1 : 32'd0);
         chk("tt_carry", 32'(c1), (i == 3) ? 32'd1 : 32'd0);
         #19;
      end

      step();
      a1 = 1; b1 = 1; v1 = 1;
      @(posedge clk); #1;
      chk("cap11_sum_q",     32'(sq1), 32'd0);
      chk("cap11_carry_q",   32'(cq1), 32'd1);
      chk("cap11_out_valid", 32'(ov1), 32'd1);

      #1;
      a1 = 0; b1 = 1; v1 = 1;
      step();
      chk("cap01_sum_q", 32'(sq1), 32'd1);
      a1 = 1; b1 = 1; v1 = 0;
      @(posedge clk); #1;
      chk("hold_sum_q",     32'(sq1), 32'd1);
      chk("hold_carry_q",   32'(cq1), 32'd0);
      chk("hold_out_valid", 32'(ov1), 32'd0);

      // Asynchronous reset between edges; combinational path keeps tracking.
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_sum_q",     32'(sq1), 32'd0);
      chk("async_rst_carry_q",   32'(cq1), 32'd0);
      chk("async_rst_out_valid", 32'(ov1), 32'd0);
      chk("rst_comb_carry",      32'(c1), 32'd1);
      a1 = 0;
      #1;
      chk("rst_comb_sum",        32'(s1), 32'd1);
      v1 = 1; b1 = 0; a1 = 1;
      step(); step();
      chk("held_in_rst_ov", 32'(ov1), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_sum_q", 32'(sq1), 32'd1);
      chk("post_rst_ov",    32'(ov1), 32'd1);
      #1;

      // Back-to-back accepted inputs on both widths.
      v4 = 1;
      for (int i = 0; i < 6; i++) begin
         {a1, b1} = vec[(i + 1) % 4];
         a4 = 4'(i * 5 + 3); b4 = 4'(i * 3 + 9);
         step();
      end
      v1 = 0; v4 = 0;

      a4 = 4'b1100; b4 = 4'b1010;
      #1;
      chk("w4_sum_vec",   32'(s4), 32'h6);
      chk("w4_carry_vec", 32'(c4), 32'h8);
      step();

      a4 = {1'bx, 3'b010}; b4 = 4'b0110;
      #1;
      chk("xlane_sum",   32'(s4[2:0]), 32'h4);
      chk("xlane_carry", 32'(c4[2:0]), 32'h2);
      step(); step();
      a4 = 4'b0101; b4 = 4'b0011; v4 = 1;
      step();
      v4 = 0;
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter WIDTH, default 1: number of independent 1-bit half-adder lanes.
REQ-002 Parameter REG_EN, default 1: 1 builds the registered output stage; 0 ties sum_q/carry_q/out_valid to 0.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for the registered stage.
REQ-005 rst  input  1  asynchronous, active-high reset of all registers.
REQ-006 ip1  input  WIDTH  first operand, one bit per lane.
REQ-007 ip2  input  WIDTH  second operand, one bit per lane.
REQ-008 in_valid  input  1  qualifies ip1/ip2 for capture by the registered stage.
REQ-009 sum  output  WIDTH  combinational per-lane sum.
REQ-010 carry  output  WIDTH  combinational per-lane carry.
REQ-011 sum_q  output  WIDTH  registered sum.
REQ-012 carry_q  output  WIDTH  registered carry.
REQ-013 out_valid  output  1  high for the cycle after an accepted input.

Function
REQ-014 Each lane i SHALL compute sum[i] = ip1[i] XOR ip2[i] and carry[i] = ip1[i] AND ip2[i]; there is no carry between lanes.
REQ-015 sum and carry SHALL be purely combinational: zero latency, independent of clk and rst, and updated in the same timestep as any input change.
REQ-016 On a rising clk edge with in_valid=1, sum_q and carry_q SHALL load the current combinational sum and carry (1-cycle latency).
REQ-017 On a rising clk edge with in_valid=0, sum_q and carry_q SHALL hold their values.
REQ-018 out_valid SHALL equal in_valid registered by one cycle.
REQ-019 No backpressure exists: every valid input SHALL be accepted, and back-to-back valid inputs SHALL produce back-to-back out_valid.
REQ-020 X or Z on an input SHALL NOT corrupt lanes whose inputs are known.

Reset
REQ-021 While rst=1, sum_q, carry_q and out_valid SHALL be 0 immediately, without waiting for a clock edge.
REQ-022 Reset asserted mid-operation SHALL discard the pending result; the first capture after rst deasserts SHALL occur on the first rising edge with rst=0 and in_valid=1.
REQ-023 sum and carry SHALL be unaffected by rst.

Structure
REQ-024 No shared package is required; WIDTH and REG_EN are module parameters only.
REQ-025 The per-lane logic SHALL be a sub-module, ha_bit (1-bit combinational half adder), instantiated WIDTH times in a generate loop.
REQ-026 The registered stage SHALL live in half_adder, guarded by a REG_EN generate block.

Verification
REQ-027 With WIDTH=1, apply (ip1,ip2) = 00, 01, 10, 11 at 20 ns intervals -> sum/carry = 0/0, 1/0, 1/0, 0/1 in the same timestep as each change.
REQ-028 With WIDTH=1, hold in_valid=1 and apply ip1=1, ip2=1 before edge k -> at edge k, sum_q=0, carry_q=1, out_valid=1.
REQ-029 Capture 01 with in_valid=1, then drop in_valid and apply 11 -> sum_q=1 and carry_q=0 hold, out_valid=0 one cycle later.
REQ-030 Assert rst between clock edges with sum_q=1 -> sum_q, carry_q and out_valid read 0 before the next edge, while sum/carry still track the inputs.
REQ-031 With WIDTH=4, ip1=4'b1100 and ip2=4'b1010 -> sum=4'b0110, carry=4'b1000.
REQ-032 With WIDTH=4, drive ip1[3]=X and lanes 0-2 known -> sum[2:0] and carry[2:0] are correct.
